pipeline_control: RTL and testbench
===================================

# pipeline_control

Central stall/flush sequencer for the five-stage LC-3b pipeline. It drives the `stall` and `reset` (flush) inputs of the four pipeline barriers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC load enable. It also sequences the two-access LDI/STI memory phase and keeps saturating stall/flush statistics. It sits in the top-level datapath, between the cache response signals, the hazard-relevant stage fields and the barrier control pins.

## Interface
Parameters:
- `CNT_W`, 16, width of the statistics counters.

Ports:
- `clk`  in  1  pipeline clock.
- `reset`  in  1  asynchronous, active-high reset.
- `imem_read`  in  1  IF stage has an instruction fetch outstanding.
- `imem_resp`  in  1  I-side memory response this cycle.
- `dmem_req`  in  1  MEM stage holds a valid load/store.
- `dmem_resp`  in  1  D-side memory response this cycle.
- `mem_indirect`  in  1  MEM-stage instruction is LDI/STI (valid qualified).
- `mem_br_taken`  in  1  valid MEM-stage control transfer redirects PC (BR taken, JMP, JSR, TRAP).
- `ex_is_load`  in  1  valid ID/EX instruction writes a register from memory.
- `ex_dest`  in  3  destination register of that load.
- `id_sr1`, `id_sr2`  in  3 each  IF/ID source registers.
- `id_sr1_used`, `id_sr2_used`  in  1 each  source actually read (valid qualified).
- `pc_stall`  out  1  hold PC.
- `stall_if_id`, `stall_id_ex`, `stall_ex_mem`, `stall_mem_wb`  out  1 each  barrier stall.
- `flush_if_id`, `flush_id_ex`, `flush_ex_mem`, `flush_mem_wb`  out  1 each  barrier synchronous reset.
- `mem_phase`  out  1  0 = first/only D access, 1 = indirect second access.
- `stall_count`, `flush_count`  out  CNT_W each  statistics.

## Operation
- Barriers clear only when `reset` is high and `stall` is low. Therefore any flush_X=1 requires stall_X=0 in the same cycle.
- State machine `{RUN, IND2}`.
- Wait conditions:
  - `imem_wait = imem_read & ~imem_resp`
  - `dmem_wait = dmem_req & ~dmem_resp`
  - `ind_first = (state==RUN) & mem_indirect & dmem_req & dmem_resp`
- Priority, highest first, evaluated each cycle in RUN:
  1. `reset`: all stalls 0, all flushes 1, pc_stall 0.
  2. `dmem_wait | imem_wait | ind_first`: freeze. pc_stall and all four stalls = 1; flushes 0.
  3. `mem_br_taken`: pc_stall 0 (PC loads target). flush_if_id, flush_id_ex and flush_ex_mem = 1. MEM/WB advances normally.
  4. Load-use hazard, `ex_is_load & ((id_sr1_used & id_sr1==ex_dest) | (id_sr2_used & id_sr2==ex_dest))`: pc_stall = stall_if_id = 1; flush_id_ex = 1 (bubble); EX/MEM and MEM/WB advance.
  5. Otherwise all outputs 0.
- Transitions:
  - RUN→IND2 on `ind_first`.
  - In IND2: mem_phase=1 and the pipeline freezes while `dmem_wait`. Exit IND2→RUN on `dmem_req & dmem_resp`; that cycle is treated as RUN with priority 2 skipped for the D side (normal advance rules 3–5 apply).
- mem_phase=0 in RUN.
- Branch and load-use together: branch wins; the hazarding instruction is flushed.
- `mem_br_taken` during a freeze is not acted on until the freeze ends. The instruction is held in MEM, so no flush is lost.
- Counters:
  - stall_count +1 on each cycle with pc_stall=1 outside reset.
  - flush_count +1 on each cycle rule 3 fires.
  - Both saturate at all-ones.

## Timing
- All barrier/PC outputs are combinational (Mealy) from the current state and inputs, with zero latency.
- state, mem_phase and the counters are registered on posedge `clk`.
- Asynchronous reset: state=RUN, mem_phase=0, counters=0 immediately. Flush outputs are 1 for as long as `reset` is high.
- Reset mid-indirect: returns to RUN; the second access is abandoned.
- Load-use costs exactly 1 bubble cycle. A taken branch costs 3 flushed slots. An indirect op costs the memory latency of both accesses plus the freeze.
- Simultaneous `imem_resp` and `dmem_wait`: stay frozen; the fetched instruction is held by the stalled IF stage.

## Structure
- Add enum `lc3b_pipe_ctrl_state` {RUN, IND2} to the shared `lc3b_types` package. Add `lc3b_reg` (3-bit) there if it is not already present.
- Sub-module `load_use_detect`: purely combinational comparison of `ex_dest` against the ID sources, producing the hazard bit.
- The top level holds the FSM, the priority logic and the counters.

## Test plan
- Reset held 2 cycles: all flush outputs=1, stalls=0; afterwards counters=0, mem_phase=0, all outputs 0 with idle inputs.
- Load-use (LDR R1; ADD R2,R1,R3): ex_is_load=1, ex_dest=1, id_sr1=1, id_sr1_used=1 → one cycle of pc_stall=stall_if_id=flush_id_ex=1; stall_count=1.
- Taken branch, no waits: mem_br_taken=1 → flush_if_id=flush_id_ex=flush_ex_mem=1, pc_stall=0, stall_mem_wb=0; flush_count=1. Same cycle with a load-use hazard → identical response.
- D miss for 4 cycles then resp: all stalls=1 for 4 cycles, released on the resp cycle; stall_count=4.
- LDI with 2-cycle D latency per access: freeze through the first resp, mem_phase=1, freeze until the second resp, then advance with mem_phase=0.
- Saturation: preload with 0xFFFE stall cycles → stall_count reaches 0xFFFF and holds.

Source files
------------

// File: rtl/pipeline_control_pkg.sv
// Shared types for the LC-3b pipeline stall/flush sequencer.
package pipeline_control_pkg;

  // Register specifier width used across the LC-3b datapath
  typedef logic [2:0] lc3b_reg;

  // RUN:  normal issue, first (or only) D access of a MEM op
  // IND2: second D access of an LDI/STI is in progress
  typedef enum logic {
    RUN  = 1'b0,
    IND2 = 1'b1
  } lc3b_pipe_ctrl_state;

endpackage

// File: rtl/pipeline_control_load_use_detect.sv
// Load-use hazard detection: a load in ID/EX whose destination is read by the
// instruction currently in IF/ID.
module pipeline_control_load_use_detect
  import pipeline_control_pkg::*;
(
  input  logic    ex_is_load,
  input  lc3b_reg ex_dest,
  input  lc3b_reg id_sr1,
  input  lc3b_reg id_sr2,
  input  logic    id_sr1_used,
  input  logic    id_sr2_used,
  output logic    hazard
);

  logic sr1_hit;
  logic sr2_hit;

  // Compare each live source register against the pending load's destination
  always_comb begin
    sr1_hit = id_sr1_used & (id_sr1 == ex_dest);
    sr2_hit = id_sr2_used & (id_sr2 == ex_dest);
    hazard  = ex_is_load & (sr1_hit | sr2_hit);
  end

endmodule

// File: rtl/pipeline_control.sv
// Central stall/flush sequencer for the five-stage LC-3b pipeline.
//
// state | meaning
// RUN   | normal issue; MEM op performs its first/only D access
// IND2  | LDI/STI second D access outstanding (mem_phase = 1)
module pipeline_control
  import pipeline_control_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             imem_read,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  logic             mem_indirect,
  input  logic             mem_br_taken,
  input  logic             ex_is_load,
  input  logic [2:0]       ex_dest,
  input  logic [2:0]       id_sr1,
  input  logic [2:0]       id_sr2,
  input  logic             id_sr1_used,
  input  logic             id_sr2_used,
  output logic             pc_stall,
  output logic             stall_if_id,
  output logic             stall_id_ex,
  output logic             stall_ex_mem,
  output logic             stall_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic             flush_mem_wb,
  output logic             mem_phase,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  lc3b_pipe_ctrl_state state;

  logic hazard;
  logic imem_wait;
  logic dmem_wait;
  logic dmem_done;
  logic ind_first;
  logic freeze;
  logic br_fire;

  pipeline_control_load_use_detect u_load_use (
    .ex_is_load  (ex_is_load),
    .ex_dest     (ex_dest),
    .id_sr1      (id_sr1),
    .id_sr2      (id_sr2),
    .id_sr1_used (id_sr1_used),
    .id_sr2_used (id_sr2_used),
    .hazard      (hazard)
  );

  // Priority-ordered barrier/PC control, combinational from state and inputs.
  // ind_first is RUN-qualified, so in IND2 the completing D handshake does not
  // freeze and the normal advance rules take over on the exit cycle.
  always_comb begin
    imem_wait    = imem_read & ~imem_resp;
    dmem_wait    = dmem_req & ~dmem_resp;
    dmem_done    = dmem_req & dmem_resp;
    ind_first    = (state == RUN) & mem_indirect & dmem_done;
    freeze       = imem_wait | dmem_wait | ind_first;
    br_fire      = 1'b0;
    pc_stall     = 1'b0;
    stall_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    stall_ex_mem = 1'b0;
    stall_mem_wb = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    flush_mem_wb = 1'b0;
    if (reset) begin
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      flush_ex_mem = 1'b1;
      flush_mem_wb = 1'b1;
    end else if (freeze) begin
      pc_stall     = 1'b1;
      stall_if_id  = 1'b1;
      stall_id_ex  = 1'b1;
      stall_ex_mem = 1'b1;
      stall_mem_wb = 1'b1;
    end else if (mem_br_taken) begin
      // Branch wins over load-use: the hazarding instruction is squashed anyway
      br_fire      = 1'b1;
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      flush_ex_mem = 1'b1;
    end else if (hazard) begin
      pc_stall     = 1'b1;
      stall_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
    end
  end

  // Indirect-access sequencer with registered mem_phase. Leaving IND2 waits
  // for the pipeline to actually advance so the LDI/STI is not re-seen in RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      mem_phase <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (ind_first) begin
            state     <= IND2;
            mem_phase <= 1'b1;
          end
        end
        IND2: begin
          if (dmem_done & ~imem_wait) begin
            state     <= RUN;
            mem_phase <= 1'b0;
          end
        end
        default: begin
          state     <= RUN;
          mem_phase <= 1'b0;
        end
      endcase
    end
  end

  // Saturating statistics: PC-hold cycles and taken-branch flushes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (pc_stall && !(&stall_count)) stall_count <= stall_count + 1'b1;
      if (br_fire && !(&flush_count)) flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_control.sv
module tb_pipeline_control;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_read = 0, imem_resp = 0, dmem_req = 0, dmem_resp = 0;
  logic        mem_indirect = 0, mem_br_taken = 0, ex_is_load = 0;
  logic [2:0]  ex_dest = 0, id_sr1 = 0, id_sr2 = 0;
  logic        id_sr1_used = 0, id_sr2_used = 0;
  logic        pc_stall, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
  logic        flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb, mem_phase;
  logic [15:0] stall_count, flush_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  pipeline_control #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .imem_read(imem_read), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .mem_indirect(mem_indirect), .mem_br_taken(mem_br_taken),
    .ex_is_load(ex_is_load), .ex_dest(ex_dest),
    .id_sr1(id_sr1), .id_sr2(id_sr2),
    .id_sr1_used(id_sr1_used), .id_sr2_used(id_sr2_used),
    .pc_stall(pc_stall),
    .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
    .stall_ex_mem(stall_ex_mem), .stall_mem_wb(stall_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .flush_ex_mem(flush_ex_mem), .flush_mem_wb(flush_mem_wb),
    .mem_phase(mem_phase), .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference model: second-access flag and event counts kept as plain integers
  bit          m_second = 0;
  int unsigned m_stalls = 0;
  int unsigned m_flushes = 0;

  always begin
    bit       iw, dw, dhs, hz, frozen, redirect, n_second;
    logic [3:0] e_st, e_fl;
    logic       e_pc;
    logic [59:0] exp_v, act_v;
    @(negedge clk);
    if (reset) begin
      m_second = 0; m_stalls = 0; m_flushes = 0;
    end
    iw  = imem_read && !imem_resp;
    dw  = dmem_req && !dmem_resp;
    dhs = dmem_req && dmem_resp;
    hz  = ex_is_load && ((id_sr1_used && id_sr1 == ex_dest) || (id_sr2_used && id_sr2 == ex_dest));
    frozen   = !reset && (iw || dw || (!m_second && mem_indirect && dhs));
    redirect = !reset && !frozen && mem_br_taken;
    e_pc = 0; e_st = 4'b0000; e_fl = 4'b0000;
    if (reset)         e_fl = 4'b1111;
    else if (frozen)   begin e_pc = 1; e_st = 4'b1111; end
    else if (redirect) e_fl = 4'b1110;
    else if (hz)       begin e_pc = 1; e_st = 4'b1000; e_fl = 4'b0100; end
    exp_v = {e_pc, e_st, e_fl, m_second, 10'd0, m_stalls[15:0], m_flushes[15:0]};
    act_v = {pc_stall, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
             flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb, mem_phase,
             10'd0, stall_count, flush_count};
    chk("model", act_v[59:0], exp_v[59:0]);
    if (!m_second) n_second = mem_indirect && dhs && !reset;
    else           n_second = !(dhs && !iw);
    @(posedge clk);
    if (reset) begin
      m_second = 0; m_stalls = 0; m_flushes = 0;
    end else begin
      m_second = n_second;
      if (e_pc && m_stalls < 65535) m_stalls++;
      if (redirect && m_flushes < 65535) m_flushes++;
    end
  end

  task automatic idle();
    imem_read = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0;
    mem_indirect = 0; mem_br_taken = 0; ex_is_load = 0;
    ex_dest = 0; id_sr1 = 0; id_sr2 = 0; id_sr1_used = 0; id_sr2_used = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {pc_stall, stalls[4], flushes[4]}
  function automatic logic [8:0] ctl();
    return {pc_stall, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
            flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb};
  endfunction

  initial begin
    idle();
    reset = 1;
    @(negedge clk); chk("reset_ctl_a", 32'(ctl()), 32'h00F);
    tick();
    @(negedge clk); chk("reset_ctl_b", 32'(ctl()), 32'h00F);
    tick();
    reset = 0;
    @(negedge clk);
    chk("idle_ctl", 32'(ctl()), 32'h000);
    chk("idle_sc", 32'(stall_count), 0);
    chk("idle_fc", 32'(flush_count), 0);
    chk("idle_phase", 32'(mem_phase), 0);
    tick();

    // LDR R1; ADD R2,R1,R3
    ex_is_load = 1; ex_dest = 3'd1; id_sr1 = 3'd1; id_sr1_used = 1; id_sr2 = 3'd3; id_sr2_used = 1;
    @(negedge clk); chk("lu_ctl", 32'(ctl()), 32'h184);
    tick(); idle();
    @(negedge clk); chk("lu_ctl_after", 32'(ctl()), 32'h000); chk("lu_sc", 32'(stall_count), 1);
    tick();
    // Matching source that is not read: no hazard
    ex_is_load = 1; ex_dest = 3'd5; id_sr1 = 3'd5; id_sr1_used = 0;
    @(negedge clk); chk("lu_unused", 32'(ctl()), 32'h000);
    tick();
    // Hazard through sr2
    id_sr2 = 3'd5; id_sr2_used = 1;
    @(negedge clk); chk("lu_sr2", 32'(ctl()), 32'h184);
    tick(); idle();

    // Taken branch, then branch together with load-use
    mem_br_taken = 1;
    @(negedge clk); chk("br_ctl", 32'(ctl()), 32'h00E);
    tick(); idle();
    @(negedge clk); chk("br_fc", 32'(flush_count), 1);
    tick();
    mem_br_taken = 1; ex_is_load = 1; ex_dest = 3'd1; id_sr1 = 3'd1; id_sr1_used = 1;
    @(negedge clk); chk("br_lu_ctl", 32'(ctl()), 32'h00E);
    tick(); idle();
    @(negedge clk); chk("br_lu_fc", 32'(flush_count), 2); chk("br_lu_sc", 32'(stall_count), 2);
    tick();

    // D miss for 4 cycles after a fresh reset
    reset = 1; tick(); reset = 0;
    dmem_req = 1; dmem_resp = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("dmiss_ctl", 32'(ctl()), 32'h1F0);
      tick();
    end
    dmem_resp = 1;
    @(negedge clk); chk("dmiss_release", 32'(ctl()), 32'h000);
    tick(); idle();
    @(negedge clk); chk("dmiss_sc", 32'(stall_count), 4); chk("dmiss_fc", 32'(flush_count), 0);
    tick();

    // LDI with 2-cycle latency per access
    mem_indirect = 1; dmem_req = 1; dmem_resp = 0;
    @(negedge clk); chk("ldi_c1", 32'(ctl()), 32'h1F0); tick();
    dmem_resp = 1;
    @(negedge clk); chk("ldi_c2", 32'(ctl()), 32'h1F0); chk("ldi_c2_ph", 32'(mem_phase), 0); tick();
    dmem_resp = 0;
    @(negedge clk); chk("ldi_c3", 32'(ctl()), 32'h1F0); chk("ldi_c3_ph", 32'(mem_phase), 1); tick();
    dmem_resp = 1;
    @(negedge clk); chk("ldi_c4", 32'(ctl()), 32'h000); chk("ldi_c4_ph", 32'(mem_phase), 1); tick();
    idle();
    @(negedge clk); chk("ldi_done_ph", 32'(mem_phase), 0); chk("ldi_sc", 32'(stall_count), 7);
    tick();

    // Branch held during a D miss with an I response in flight
    dmem_req = 1; dmem_resp = 0; mem_br_taken = 1; imem_read = 1; imem_resp = 1;
    @(negedge clk); chk("frz_br_ctl", 32'(ctl()), 32'h1F0); tick();
    dmem_resp = 1;
    @(negedge clk); chk("frz_br_release", 32'(ctl()), 32'h00E); tick();
    idle();
    @(negedge clk); chk("frz_br_fc", 32'(flush_count), 1); chk("frz_br_sc", 32'(stall_count), 8);
    tick();

    // Reset while the second indirect access is pending
    mem_indirect = 1; dmem_req = 1; dmem_resp = 1; tick();
    dmem_resp = 0;
    @(negedge clk); chk("ind_pending_ph", 32'(mem_phase), 1); tick();
    reset = 1;
    @(negedge clk); chk("ind_rst_ph", 32'(mem_phase), 0); chk("ind_rst_ctl", 32'(ctl()), 32'h00F);
    tick(); reset = 0; idle();
    @(negedge clk); chk("ind_rst_after", 32'(ctl()), 32'h000); chk("ind_rst_ph2", 32'(mem_phase), 0);
    tick();

    // Saturation of stall_count
    reset = 1; tick(); reset = 0;
    dmem_req = 1; dmem_resp = 0;
    repeat (65534) tick();
    idle();
    @(negedge clk); chk("sat_fffe", 32'(stall_count), 32'hFFFE); tick();
    dmem_req = 1; dmem_resp = 0;
    repeat (3) tick();
    idle();
    @(negedge clk); chk("sat_ffff", 32'(stall_count), 32'hFFFF); tick();
    @(negedge clk); chk("sat_hold", 32'(stall_count), 32'hFFFF);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
